series_collector_10_hrx2: RTL and testbench
===========================================

Name: series_collector_10_hrx2

Overview:
- Receive-side companion to the two-half-round (HRx2) vector datapath blocks.
- Accepts a 10-element result vector delivered as two 5-element series over consecutive handshakes (first series = elements 0..4, second = 5..9).
- Reassembles the two series into one registered 10-element vector and pulses a vector-valid strobe.
- Sits downstream of the HRx2 adders and feeds full-width consumers.

Parameters:
- IN_WIDTH, 11, width of each signed element (adder sum width).
- COUNT_WIDTH, 16, width of the completed-vector counter.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- enable  input  1  clock enable; when low, all state holds except vecReady
- inReady  input  1  one-cycle strobe: D0..D4 and inSeries valid this cycle
- inSeries  input  1  series tag: 0 = elements 0..4, 1 = elements 5..9
- D0, D1, D2, D3, D4  input  IN_WIDTH each, signed  incoming series elements
- readyForFirstSeries  output  1  high while expecting a first series
- V0 … V9  output  IN_WIDTH each, signed  assembled vector, registered
- vecReady  output  1  one-cycle pulse: V0..V9 updated
- vecCount  output  COUNT_WIDTH  completed vectors, wraps
- seriesError  output  1  sticky framing error (feature-dependent)

Behaviour:
- Reset values: state = HALF0; readyForFirstSeries = 1; staging regs = 0; V0..V9 = 0; vecReady = 0; vecCount = 0; seriesError = 0.
- Reset mid-vector discards any captured first half.
- State machine:
  - HALF0 & enable & inReady:
    - Capture D0..D4 into staging registers.
    - Go to HALF1.
    - readyForFirstSeries <= 0.
  - HALF1 & enable & inReady:
    - In the same edge: V0..V4 <= staging; V5..V9 <= D0..D4.
    - vecReady <= 1; vecCount <= vecCount + 1 (modulo 2^COUNT_WIDTH).
    - Go to HALF0; readyForFirstSeries <= 1.
- Latency: vecReady and the new V0..V9 are visible in the cycle after the second-series handshake edge.
- Back-to-back: a first series arriving the cycle after completion is accepted.
  - V0..V9 hold the completed vector until the next completion; staging is separate, so a new first half never disturbs V0..V4.
- vecReady:
  - Single-cycle pulse.
  - Cleared on every edge that is not a completion, including edges with enable low, so it never stretches.
- enable low: inReady ignored; state, staging, V0..V9, vecCount and seriesError hold.
- No arithmetic; elements are passed through bit-exact, sign preserved.

Optional Feature:
- Macro: SERIES_CHECK_EN
- Defined: inSeries is checked against the expected half on every accepted inReady.
  - HALF0 with inSeries = 1 (orphan second half): data dropped, stay in HALF0, seriesError <= 1.
  - HALF1 with inSeries = 0 (new first half before completion): staging overwritten with D0..D4, stay in HALF1, seriesError <= 1. This resyncs to the newest first half.
  - seriesError is sticky and is cleared only by reset.
- Undefined:
  - inSeries is ignored; halves are assigned purely by the internal toggle.
  - seriesError is tied to 0.

Test Plan:
- Reset, then series D = {1,2,3,4,5} followed next cycle by {6,7,8,9,10} -> one cycle later V0..V9 = 1..10, vecReady high for exactly 1 cycle, vecCount = 1, readyForFirstSeries = 1.
- Negative values: series {-1,-512,0,511,-3} then {-1024,1023,0,0,-7} with IN_WIDTH = 11 -> V outputs match bit-exact, sign preserved.
- Three vectors back-to-back (6 consecutive inReady) -> vecReady pulses on cycles 3, 5 and 7 after the first strobe; vecCount = 3; V0..V4 unchanged between pulses.
- First series, then enable low for 4 cycles with inReady toggling, then enable high and second series -> inputs during enable low are ignored; the vector is built from the two enabled series only.
- First series, reset asserted for 1 cycle, then series {11..15}, {16..20} -> V0..V9 = 11..20; the pre-reset half is discarded; vecCount = 1.
- With SERIES_CHECK_EN defined: inSeries = 1 first (orphan), then {1..5}/0, {9,9,9,9,9}/0, {6..10}/1 -> seriesError = 1; V = {9,9,9,9,9,6,7,8,9,10}; vecCount = 1.

Source files
------------

// File: rtl/series_collector_10_hrx2.sv
// rtl/series_collector_10_hrx2.sv - reassembles two 5-element HRx2 series into one 10-element vector
// Optional build macro SERIES_CHECK_EN: checks inSeries tags and raises sticky seriesError on framing faults.
module series_collector_10_hrx2 #(
   parameter int IN_WIDTH    = 11,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       inReady,
   input  logic                       inSeries,
   input  logic signed [IN_WIDTH-1:0] D0,
   input  logic signed [IN_WIDTH-1:0] D1,
   input  logic signed [IN_WIDTH-1:0] D2,
   input  logic signed [IN_WIDTH-1:0] D3,
   input  logic signed [IN_WIDTH-1:0] D4,
   output logic                       readyForFirstSeries,
   output logic signed [IN_WIDTH-1:0] V0,
   output logic signed [IN_WIDTH-1:0] V1,
   output logic signed [IN_WIDTH-1:0] V2,
   output logic signed [IN_WIDTH-1:0] V3,
   output logic signed [IN_WIDTH-1:0] V4,
   output logic signed [IN_WIDTH-1:0] V5,
   output logic signed [IN_WIDTH-1:0] V6,
   output logic signed [IN_WIDTH-1:0] V7,
   output logic signed [IN_WIDTH-1:0] V8,
   output logic signed [IN_WIDTH-1:0] V9,
   output logic                       vecReady,
   output logic [COUNT_WIDTH-1:0]     vecCount,
   output logic                       seriesError
);

   typedef enum logic {
      HALF0 = 1'b0,
      HALF1 = 1'b1
   } stateT;

   stateT                      state;
   logic signed [IN_WIDTH-1:0] stage0, stage1, stage2, stage3, stage4;
   logic                       accept;

   assign accept = enable & inReady;

`ifdef SERIES_CHECK_EN
   logic seriesErrorReg;
   assign seriesError = seriesErrorReg;
`else
   logic unusedInSeries;
   assign unusedInSeries = inSeries;
   assign seriesError    = 1'b0;
`endif

   // Half-vector sequencer: stage the first series, publish the full vector on the second.
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= HALF0;
         readyForFirstSeries <= 1'b1;
         stage0 <= '0; stage1 <= '0; stage2 <= '0; stage3 <= '0; stage4 <= '0;
         V0 <= '0; V1 <= '0; V2 <= '0; V3 <= '0; V4 <= '0;
         V5 <= '0; V6 <= '0; V7 <= '0; V8 <= '0; V9 <= '0;
         vecReady            <= 1'b0;
         vecCount            <= '0;
`ifdef SERIES_CHECK_EN
         seriesErrorReg      <= 1'b0;
`endif
      end else begin
         // Strobe is dropped on every non-completing edge, enabled or not.
         vecReady <= 1'b0;
         if (accept) begin
            case (state)
               HALF0: begin
`ifdef SERIES_CHECK_EN
                  if (inSeries) begin
                     // Orphan second half: discard data, remain waiting for a first half.
                     seriesErrorReg <= 1'b1;
                  end else
`endif
                  begin
                     stage0 <= D0; stage1 <= D1; stage2 <= D2; stage3 <= D3; stage4 <= D4;
                     state               <= HALF1;
                     readyForFirstSeries <= 1'b0;
                  end
               end
               HALF1: begin
`ifdef SERIES_CHECK_EN
                  if (!inSeries) begin
                     // A fresh first half replaces the stale one so we resync to the newest data.
                     stage0 <= D0; stage1 <= D1; stage2 <= D2; stage3 <= D3; stage4 <= D4;
                     seriesErrorReg <= 1'b1;
                  end else
`endif
                  begin
                     V0 <= stage0; V1 <= stage1; V2 <= stage2; V3 <= stage3; V4 <= stage4;
                     V5 <= D0;     V6 <= D1;     V7 <= D2;     V8 <= D3;     V9 <= D4;
                     vecReady            <= 1'b1;
                     vecCount            <= vecCount + 1'b1;
                     state               <= HALF0;
                     readyForFirstSeries <= 1'b1;
                  end
               end
               default: begin
                  state               <= HALF0;
                  readyForFirstSeries <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_series_collector_10_hrx2.sv
// tb/tb_series_collector_10_hrx2.sv - self-checking bench for series_collector_10_hrx2
module tb_series_collector_10_hrx2;

   localparam int IW = 11;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic reset, enable, inReady, inSeries;
   logic signed [IW-1:0] D0, D1, D2, D3, D4;
   logic readyForFirstSeries, vecReady, seriesError;
   logic signed [IW-1:0] V0, V1, V2, V3, V4, V5, V6, V7, V8, V9;
   logic [CW-1:0] vecCount;
   logic signed [IW-1:0] vOut [10];

   int nCompared = 0;
   int nMismatched = 0;

   series_collector_10_hrx2 #(.IN_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .inSeries(inSeries),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
      .readyForFirstSeries(readyForFirstSeries),
      .V0(V0), .V1(V1), .V2(V2), .V3(V3), .V4(V4),
      .V5(V5), .V6(V6), .V7(V7), .V8(V8), .V9(V9),
      .vecReady(vecReady), .vecCount(vecCount), .seriesError(seriesError)
   );

   assign vOut[0] = V0; assign vOut[1] = V1; assign vOut[2] = V2; assign vOut[3] = V3;
   assign vOut[4] = V4; assign vOut[5] = V5; assign vOut[6] = V6; assign vOut[7] = V7;
   assign vOut[8] = V8; assign vOut[9] = V9;

   always #5 clk = ~clk;

   // Reference model: a pending first half kept as a queue; a full vector forms when a second half joins it.
   int mPend[$];
   int mV[10];
   int mCount;
   bit mVr;
   bit mErr;

   task automatic modelStep(input bit rst, input bit en, input bit rdy, input bit ser, input int d[5]);
      bit normal;
      if (rst) begin
         mPend.delete();
         foreach (mV[i]) mV[i] = 0;
         mCount = 0; mVr = 0; mErr = 0;
         return;
      end
      mVr = 0;
      if (!(en && rdy)) return;
      normal = 1;
`ifdef SERIES_CHECK_EN
      if (mPend.size() == 0 && ser) begin
         mErr = 1; normal = 0;
      end else if (mPend.size() != 0 && !ser) begin
         mPend.delete();
         for (int i = 0; i < 5; i++) mPend.push_back(d[i]);
         mErr = 1; normal = 0;
      end
`else
      if (ser) normal = 1;
`endif
      if (normal) begin
         if (mPend.size() == 0) begin
            for (int i = 0; i < 5; i++) mPend.push_back(d[i]);
         end else begin
            for (int i = 0; i < 5; i++) begin
               mV[i] = mPend[i];
               mV[i+5] = d[i];
            end
            mPend.delete();
            mCount = (mCount + 1) % (1 << CW);
            mVr = 1;
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkModel(input string tag);
      int badIdx;
      badIdx = -1;
      for (int i = 9; i >= 0; i--) if (int'(vOut[i]) != mV[i]) badIdx = i;
      check({tag, ".vecReady"}, int'(vecReady), int'(mVr));
      check({tag, ".readyForFirstSeries"}, int'(readyForFirstSeries), (mPend.size() == 0) ? 1 : 0);
      check({tag, ".vecCount"}, int'(vecCount), mCount);
      check({tag, ".seriesError"}, int'(seriesError), int'(mErr));
      if (badIdx >= 0) check($sformatf("%s.V%0d", tag, badIdx), int'(vOut[badIdx]), mV[badIdx]);
      else check({tag, ".V"}, 0, 0 * badIdx);
   endtask

   // One clock: drive inputs, advance, update model, settle past the edge.
   task automatic step(input bit rst, input bit en, input bit rdy, input bit ser, input int d[5]);
      reset = rst; enable = en; inReady = rdy; inSeries = ser;
      D0 = IW'(d[0]); D1 = IW'(d[1]); D2 = IW'(d[2]); D3 = IW'(d[3]); D4 = IW'(d[4]);
      @(posedge clk);
      modelStep(rst, en, rdy, ser, d);
      #1;
   endtask

   typedef struct {
      bit rst; bit en; bit rdy; bit ser; int base;
      bit expVr; bit expRf; int expCnt; int expV0; int expV9;
   } vecT;

   vecT tbl[$];
   int d[5];
   int expNeg[10];

   initial begin
      reset = 1; enable = 0; inReady = 0; inSeries = 0;
      D0 = '0; D1 = '0; D2 = '0; D3 = '0; D4 = '0;
      foreach (d[i]) d[i] = 0;

      // Reset state
      step(1, 0, 0, 0, d);
      step(1, 1, 1, 0, d);
      check("reset.readyForFirstSeries", int'(readyForFirstSeries), 1);
      check("reset.vecReady", int'(vecReady), 0);
      check("reset.vecCount", int'(vecCount), 0);
      check("reset.seriesError", int'(seriesError), 0);
      check("reset.V0", int'(V0), 0);
      check("reset.V9", int'(V9), 0);

      // rst en rdy ser base | vr rf cnt V0 V9
      tbl = '{
         '{0,1,1,0, 1,  0,0,0, 0, 0},
         '{0,1,1,1, 6,  1,1,1, 1,10},
         '{0,1,0,0, 0,  0,1,1, 1,10},
         '{0,1,1,0,21,  0,0,1, 1,10},
         '{0,1,1,1,26,  1,1,2,21,30},
         '{0,1,1,0,31,  0,0,2,21,30},
         '{0,1,1,1,36,  1,1,3,31,40},
         '{0,1,1,0,41,  0,0,3,31,40},
         '{0,1,1,1,46,  1,1,4,41,50},
         '{0,1,1,0,51,  0,0,4,41,50},
         '{0,0,1,1,100, 0,0,4,41,50},
         '{0,0,0,0,0,   0,0,4,41,50},
         '{0,0,1,0,200, 0,0,4,41,50},
         '{0,0,0,1,0,   0,0,4,41,50},
         '{0,1,1,1,56,  1,1,5,51,60},
         '{0,1,1,0,61,  0,0,5,51,60},
         '{1,1,1,0,0,   0,1,0, 0, 0},
         '{0,1,1,0,11,  0,0,0, 0, 0},
         '{0,1,1,1,16,  1,1,1,11,20}
      };
      foreach (tbl[r]) begin
         for (int k = 0; k < 5; k++) d[k] = tbl[r].base + k;
         step(tbl[r].rst, tbl[r].en, tbl[r].rdy, tbl[r].ser, d);
         check($sformatf("tbl%0d.vecReady", r), int'(vecReady), int'(tbl[r].expVr));
         check($sformatf("tbl%0d.readyFirst", r), int'(readyForFirstSeries), int'(tbl[r].expRf));
         check($sformatf("tbl%0d.vecCount", r), int'(vecCount), tbl[r].expCnt);
         check($sformatf("tbl%0d.V0", r), int'(V0), tbl[r].expV0);
         check($sformatf("tbl%0d.V9", r), int'(V9), tbl[r].expV9);
         checkModel($sformatf("tbl%0d", r));
      end

      // Signed extremes pass bit-exact
      d = '{-1, -512, 0, 511, -3};
      step(0, 1, 1, 0, d);
      d = '{-1024, 1023, 0, 0, -7};
      step(0, 1, 1, 1, d);
      expNeg = '{-1, -512, 0, 511, -3, -1024, 1023, 0, 0, -7};
      for (int i = 0; i < 10; i++) check($sformatf("neg.V%0d", i), int'(vOut[i]), expNeg[i]);
      check("neg.vecCount", int'(vecCount), 2);
      check("neg.vecReady", int'(vecReady), 1);
      step(0, 1, 0, 0, d);
      check("neg.pulseEnds", int'(vecReady), 0);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         bit rst, en, rdy, ser;
         rst = ($urandom_range(0, 63) == 0);
         en  = ($urandom_range(0, 9) < 8);
         rdy = ($urandom_range(0, 9) < 6);
`ifdef SERIES_CHECK_EN
         ser = (mPend.size() != 0);
         if ($urandom_range(0, 9) == 0) ser = ~ser;
`else
         ser = 1'($urandom_range(0, 1));
`endif
         for (int k = 0; k < 5; k++) d[k] = int'($urandom_range(0, 2047)) - 1024;
         step(rst, en, rdy, ser, d);
         checkModel($sformatf("rnd%0d", c));
      end

`ifdef SERIES_CHECK_EN
      // Framing faults: orphan second half, then a replaced first half
      d = '{0, 0, 0, 0, 0};
      step(1, 0, 0, 0, d);
      d = '{1, 2, 3, 4, 5};
      step(0, 1, 1, 1, d);
      check("chk.orphanError", int'(seriesError), 1);
      check("chk.orphanStaysHalf0", int'(readyForFirstSeries), 1);
      step(0, 1, 1, 0, d);
      d = '{9, 9, 9, 9, 9};
      step(0, 1, 1, 0, d);
      d = '{6, 7, 8, 9, 10};
      step(0, 1, 1, 1, d);
      expNeg = '{9, 9, 9, 9, 9, 6, 7, 8, 9, 10};
      for (int i = 0; i < 10; i++) check($sformatf("chk.V%0d", i), int'(vOut[i]), expNeg[i]);
      check("chk.vecCount", int'(vecCount), 1);
      check("chk.seriesError", int'(seriesError), 1);
      checkModel("chk");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
